// File: rtl/spis_pkg.sv
// Shared constants and types for the SPI slave front end: opcodes, frame
// lengths and the frame decoder state encoding.
package spis_pkg;

  localparam logic [3:0] SPIS_CMD_WR = 4'h1;
  localparam logic [3:0] SPIS_CMD_RD = 4'h2;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int CNT_W     = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    DUMMY  = 3'd4,
    RDATA  = 3'd5,
    IGNORE = 3'd6
  } spis_state_e;

  function automatic logic opcode_valid(input logic [3:0] op);
    return (op == SPIS_CMD_WR) || (op == SPIS_CMD_RD);
  endfunction

endpackage

// File: rtl/spis_sync.sv
// Brings sclk/ssn/sdin into the mclk domain and produces registered edge
// pulses; sdin_sync and ssn_sync are delayed to line up with the pulses.
module spis_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic mclk,
  input  logic rst,
  input  logic sclk,
  input  logic ssn,
  input  logic sdin,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ssn_sync,
  output logic ssn_rise,
  output logic ssn_fall,
  output logic sdin_sync
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ssn_q;
  logic [SYNC_STAGES-1:0] sdin_q;
  logic                   sclk_prev;
  logic                   ssn_prev;
  logic                   sclk_s;
  logic                   ssn_s;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ssn_s  = ssn_q[SYNC_STAGES-1];

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sclk_q    <= '0;
      ssn_q     <= '1;
      sdin_q    <= '0;
      sclk_prev <= 1'b0;
      ssn_prev  <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ssn_sync  <= 1'b1;
      ssn_rise  <= 1'b0;
      ssn_fall  <= 1'b0;
      sdin_sync <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ssn_q     <= {ssn_q[SYNC_STAGES-2:0], ssn};
      sdin_q    <= {sdin_q[SYNC_STAGES-2:0], sdin};
      sclk_prev <= sclk_s;
      ssn_prev  <= ssn_s;
      sclk_rise <= sclk_s & ~sclk_prev;
      sclk_fall <= ~sclk_s & sclk_prev;
      ssn_rise  <= ssn_s & ~ssn_prev;
      ssn_fall  <= ~ssn_s & ssn_prev;
      ssn_sync  <= ssn_s;
      sdin_sync <= sdin_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spis_if.sv
// SPI mode-0 slave frame decoder: turns command/address/data frames into a
// held register request and shifts read responses back out on sdout.
module spis_if
  import spis_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_BITS  = 8
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ssn,
  input  logic        sdin,
  output logic        sdout,
  output logic        sdout_oen,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [31:0] reg_addr,
  output logic [3:0]  reg_be,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] ADDR_END  = CNT_W'(CMD_BITS + ADDR_BITS);
  localparam logic [CNT_W-1:0] WDATA_END = CNT_W'(CMD_BITS + ADDR_BITS + DATA_BITS);
  localparam logic [CNT_W-1:0] DUMMY_END = CNT_W'(CMD_BITS + ADDR_BITS + DUMMY_BITS);
  localparam logic [CNT_W-1:0] RDATA_END = CNT_W'(CMD_BITS + ADDR_BITS + DUMMY_BITS + DATA_BITS);

  logic              sclk_rise;
  logic              sclk_fall;
  logic              ssn_sync;
  logic              ssn_rise;
  logic              ssn_fall;
  logic              sdin_sync;

  spis_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [31:0]       shift;
  logic [31:0]       shift_in;
  logic [31:0]       addr_q;
  logic [3:0]        be_q;
  logic              is_rd;
  logic [31:0]       rd_shadow;
  logic              pending;

  spis_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .mclk      (mclk),
    .rst       (rst),
    .sclk      (sclk),
    .ssn       (ssn),
    .sdin      (sdin),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ssn_sync  (ssn_sync),
    .ssn_rise  (ssn_rise),
    .ssn_fall  (ssn_fall),
    .sdin_sync (sdin_sync)
  );

  // Counter saturates so an over-long ignored frame can never alias a boundary.
  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 7'd1;
  assign shift_in = {shift[30:0], sdin_sync};
  assign pending  = reg_wr | reg_rd;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      is_rd     <= 1'b0;
      rd_shadow <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_be    <= '0;
      reg_wdata <= '0;
      sdout     <= 1'b0;
      sdout_oen <= 1'b1;
    end else begin
      if (reg_ack && pending) begin
        reg_wr <= 1'b0;
        reg_rd <= 1'b0;
        if (reg_rd) rd_shadow <= reg_rdata;
      end

      // Deselect wins over any simultaneous sclk edge; requests already out survive.
      if (ssn_rise) begin
        state     <= IDLE;
        cnt       <= '0;
        sdout     <= 1'b0;
        sdout_oen <= 1'b1;
      end else if (ssn_fall) begin
        state <= CMD;
        cnt   <= '0;
        shift <= '0;
      end else if (ssn_sync) begin
        cnt <= '0;
      end else begin
        case (state)
          CMD: begin
            if (sclk_rise) begin
              shift <= shift_in;
              cnt   <= cnt_next;
              if (cnt_next == CMD_END) begin
                if (opcode_valid(shift_in[7:4]) && !pending) begin
                  state <= ADDR;
                  be_q  <= shift_in[3:0];
                  is_rd <= (shift_in[7:4] == SPIS_CMD_RD);
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              shift <= shift_in;
              cnt   <= cnt_next;
              if (cnt_next == ADDR_END) begin
                addr_q <= shift_in;
                if (is_rd) begin
                  state     <= DUMMY;
                  reg_rd    <= 1'b1;
                  reg_addr  <= shift_in;
                  reg_be    <= be_q;
                  rd_shadow <= '0;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              shift <= shift_in;
              cnt   <= cnt_next;
              if (cnt_next == WDATA_END) begin
                state     <= IGNORE;
                reg_wr    <= 1'b1;
                reg_addr  <= addr_q;
                reg_be    <= be_q;
                reg_wdata <= shift_in;
              end
            end
          end
          DUMMY: begin
            if (sclk_rise) begin
              cnt <= cnt_next;
            end else if (sclk_fall && (cnt == DUMMY_END)) begin
              // Snapshot the shadow: an ack arriving after this point is not sent.
              state     <= RDATA;
              sdout     <= rd_shadow[31];
              sdout_oen <= 1'b0;
              shift     <= {rd_shadow[30:0], 1'b0};
            end
          end
          RDATA: begin
            if (sclk_rise) begin
              cnt <= cnt_next;
              if (cnt_next == RDATA_END) begin
                state     <= IGNORE;
                sdout     <= 1'b0;
                sdout_oen <= 1'b1;
              end
            end else if (sclk_fall) begin
              sdout <= shift[31];
              shift <= {shift[30:0], 1'b0};
            end
          end
          IGNORE: begin
            if (sclk_rise) cnt <= cnt_next;
          end
          IDLE: begin
            cnt <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spis_if.sv
// Bench for spis_if: directed frames from the test plan plus random frames,
// checked against expectations computed from the frame rules.
module tb_spis_if;
  import spis_pkg::*;

  localparam int DUMMY = 8;
  localparam int HALF  = 60;
  localparam int RD_BITS = 8 + 32 + DUMMY + 32;

  logic        mclk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        ssn;
  logic        sdin;
  logic        sdout;
  logic        sdout_oen;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_addr;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] rd_word;
  bit          oen_bad;
  bit          host_done;
  logic [31:0] last_addr;

  always #5 mclk = ~mclk;

  spis_if #(.SYNC_STAGES(2), .DUMMY_BITS(DUMMY)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .sclk      (sclk),
    .ssn       (ssn),
    .sdin      (sdin),
    .sdout     (sdout),
    .sdout_oen (sdout_oen),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_be    (reg_be),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack(input logic [31:0] d);
    reg_rdata = d;
    reg_ack   = 1'b1;
    @(negedge mclk);
    reg_ack   = 1'b0;
    reg_rdata = '0;
  endtask

  // Host side of one frame; in a read, bits from 40+DUMMY on are sampled from sdout.
  task automatic host_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int nbits,
                            input bit rd_phase, input bit hold_ssn);
    logic [71:0] tx;
    tx      = {cmd, addr, data};
    rd_word = '0;
    oen_bad = 1'b0;
    ssn     = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      sdin = (i < 72) ? tx[71-i] : 1'b0;
      #(HALF);
      if (rd_phase && i >= 40 + DUMMY) rd_word = {rd_word[30:0], sdout};
      if (sdout_oen !== !(rd_phase && i >= 40 + DUMMY)) oen_bad = 1'b1;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    #(HALF);
    if (!hold_ssn) ssn = 1'b1;
    sdin      = 1'b0;
    host_done = 1'b1;
    repeat (8) @(negedge mclk);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] rdata, input int nbits, input bit rd_phase,
                      input bit auto_ack);
    host_done = 1'b0;
    fork
      host_frame(cmd, addr, data, nbits, rd_phase, 1'b0);
      begin
        while (!host_done && !(auto_ack && reg_rd)) @(negedge mclk);
        if (auto_ack && reg_rd) begin
          repeat (3) @(negedge mclk);
          pulse_ack(rdata);
        end
      end
    join
  endtask

  task automatic write_and_check(input string tag, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input int ack_wait);
    xfer({SPIS_CMD_WR, be}, addr, data, 32'h0, 72, 1'b0, 1'b0);
    check({tag, "_wr"}, {31'd0, reg_wr}, 32'd1);
    check({tag, "_rd"}, {31'd0, reg_rd}, 32'd0);
    check({tag, "_be"}, {28'd0, reg_be}, {28'd0, be});
    check({tag, "_addr"}, reg_addr, addr);
    check({tag, "_wdata"}, reg_wdata, data);
    check({tag, "_oen"}, {31'd0, oen_bad}, 32'd0);
    repeat (ack_wait) @(negedge mclk);
    check({tag, "_held"}, {31'd0, reg_wr}, 32'd1);
    pulse_ack(32'h0);
    check({tag, "_drop"}, {31'd0, reg_wr}, 32'd0);
    last_addr = addr;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdv;
    int          kind;

    rst = 1'b1; sclk = 1'b0; ssn = 1'b1; sdin = 1'b0;
    reg_ack = 1'b0; reg_rdata = '0; host_done = 1'b0; last_addr = '0;
    repeat (3) @(negedge mclk);
    check("rst_ctl", {28'd0, sdout, sdout_oen, reg_wr, reg_rd}, 32'h4);
    check("rst_addr", reg_addr, 32'h0);
    check("rst_be_wdata", reg_wdata | {28'd0, reg_be}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge mclk);

    write_and_check("write", 4'hF, 32'h3000_0010, 32'hA5A5_1234, 5);

    xfer(8'h23, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, RD_BITS, 1'b1, 1'b1);
    check("read_data", rd_word, 32'hDEAD_BEEF);
    check("read_be", {28'd0, reg_be}, 32'h3);
    check("read_addr", reg_addr, 32'h0000_0040);
    check("read_oen_window", {31'd0, oen_bad}, 32'd0);
    check("read_acked", {31'd0, reg_rd}, 32'd0);
    check("read_idle_out", {30'd0, sdout, sdout_oen}, 32'h1);

    xfer(8'h2C, 32'h0000_1230, 32'h0, 32'h1234_5678, RD_BITS, 1'b1, 1'b0);
    check("late_data", rd_word, 32'h0);
    check("late_oen_window", {31'd0, oen_bad}, 32'd0);
    check("late_held", {31'd0, reg_rd}, 32'd1);
    pulse_ack(32'h1234_5678);
    check("late_drop", {31'd0, reg_rd}, 32'd0);
    last_addr = 32'h0000_1230;

    xfer(8'h5F, 32'h1111_2222, 32'h3333_4444, 32'h0, 72, 1'b0, 1'b1);
    check("bad_noreq", {30'd0, reg_wr, reg_rd}, 32'd0);
    check("bad_oen", {31'd0, oen_bad}, 32'd0);
    check("bad_hold_addr", reg_addr, last_addr);
    write_and_check("after_bad", 4'h5, 32'h0BAD_0001, 32'h7777_8888, 2);

    xfer(8'h1F, 32'hCAFE_F00D, 32'h0, 32'h0, 28, 1'b0, 1'b0);
    check("abort_noreq", {30'd0, reg_wr, reg_rd}, 32'd0);
    check("abort_hold_addr", reg_addr, last_addr);
    write_and_check("after_abort", 4'hC, 32'h4000_0004, 32'h0102_0304, 0);

    // Random frames; expectations come from the command nibble alone.
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0:       op = SPIS_CMD_WR;
        1:       op = SPIS_CMD_RD;
        default: op = 4'($urandom);
      endcase
      be  = 4'($urandom);
      a   = $urandom;
      d   = $urandom;
      rdv = $urandom;
      kind = (op == 4'h1) ? 1 : (op == 4'h2) ? 2 : 0;
      if (kind == 1) begin
        write_and_check("rnd_write", be, a, d, $urandom_range(0, 4));
      end else if (kind == 2) begin
        xfer({op, be}, a, d, rdv, RD_BITS, 1'b1, 1'b1);
        check("rnd_read_data", rd_word, rdv);
        check("rnd_read_addr", reg_addr, a);
        check("rnd_read_be", {28'd0, reg_be}, {28'd0, be});
        check("rnd_read_oen", {31'd0, oen_bad}, 32'd0);
        check("rnd_read_acked", {31'd0, reg_rd}, 32'd0);
        last_addr = a;
      end else begin
        xfer({op, be}, a, d, rdv, 72, 1'b0, 1'b1);
        check("rnd_bad_noreq", {30'd0, reg_wr, reg_rd}, 32'd0);
        check("rnd_bad_oen", {31'd0, oen_bad}, 32'd0);
        check("rnd_bad_hold_addr", reg_addr, last_addr);
      end
    end

    host_done = 1'b0;
    host_frame(8'h2F, 32'h5555_AAAA, 32'h0, 40 + 2, 1'b0, 1'b1);
    check("rstmid_pending", {31'd0, reg_rd}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rstmid_ctl", {28'd0, sdout, sdout_oen, reg_wr, reg_rd}, 32'h4);
    check("rstmid_addr", reg_addr, 32'h0);
    check("rstmid_be_wdata", reg_wdata | {28'd0, reg_be}, 32'h0);
    ssn = 1'b1;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    check("rstmid_idle", 32'(dut.state), 32'(IDLE));
    repeat (3) @(negedge mclk);
    write_and_check("after_rst", 4'h9, 32'h8000_0100, 32'hFEED_C0DE, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spis_if.md
# spis_if

SPI slave front end for the sspis path: oversamples an external SPI bus (mode 0, MSB first) on the system clock and decodes framed command/address/data transfers. Each decoded transfer becomes a single held register request (`reg_wr`/`reg_rd`) for the downstream SPI-to-Wishbone bridge. For reads, it returns the bridge's response data on `sdout`.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `sclk`, `ssn`, `sdin`; legal values 2–3.
- `DUMMY_BITS`, 8: turnaround bits between read address and read data; legal values 8–16.

- `mclk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `sclk` in 1: SPI clock, asynchronous to `mclk`, ≤ `mclk`/8.
- `ssn` in 1: SPI select, active-low.
- `sdin` in 1: MOSI.
- `sdout` out 1: MISO.
- `sdout_oen` out 1: MISO output enable, active-low.
- `reg_wr` out 1: write request, held until ack.
- `reg_rd` out 1: read request, held until ack.
- `reg_addr` out 32: request address.
- `reg_be` out 4: byte enables.
- `reg_wdata` out 32: write data.
- `reg_rdata` in 32: read data, valid with `reg_ack`.
- `reg_ack` in 1: request complete, single-cycle pulse.

## Operation
**Frame format**
- Frame = `ssn` low period.
- Byte 0 = command: [7:4] opcode (`4'h1` write, `4'h2` read), [3:0] byte enables.
- Next: 32-bit address.
- Write frame: 32-bit write data follows the address.
- Read frame: `DUMMY_BITS` turnaround bits, then 32 bits driven out on `sdout`.

**Bit handling**
- `sdin` sampled on the synchronised `sclk` rising edge.
- `sdout` updated on the synchronised `sclk` falling edge.
- 7-bit bit counter, cleared whenever `ssn` is high.

**FSM**
- IDLE → CMD on `ssn` falling edge.
- CMD → ADDR after 8 bits if the opcode is valid and no request is pending; otherwise CMD → IGNORE.
- ADDR → WDATA (write) or DUMMY (read) after 32 bits. For reads, `reg_rd` asserts on this transition.
- WDATA → IGNORE after 32 bits. `reg_wr` asserts on this transition.
- DUMMY → RDATA after `DUMMY_BITS` bits.
- RDATA → IGNORE after 32 bits.
- Any state → IDLE on `ssn` rising edge.

**Request and read data**
- `reg_addr`, `reg_be`, `reg_wdata` are registered, stable while a request is pending, and hold their last value otherwise.
- Request deasserts the cycle after `reg_ack`.
- On `reg_ack` during a read, `reg_rdata` is captured into a 32-bit read shadow. The shadow is cleared to 0 when `reg_rd` asserts.
- RDATA shifts the shadow out MSB first. If the ack has not arrived by the first data bit, the host reads zeros; there is no retry.

**Output enable**
- `sdout_oen` is low only in RDATA. `sdout` = 0 when not driving.

**Abort**
- `ssn` rising mid-frame discards partial shift data and returns to IDLE.
- A request already asserted stays asserted until `reg_ack`, because Wishbone cannot abort.

**Reset**
- All outputs 0, except `sdout_oen` = 1. FSM in IDLE. Shift register and counter 0.
- Reset mid-transfer drops any pending request immediately.

## Timing
- Input path latency: `SYNC_STAGES` + 1 `mclk` from pin to edge-detect pulse.
- `reg_wr`: high 1 `mclk` after the detected rising edge of bit 72.
- `reg_rd`: high 1 `mclk` after the detected rising edge of bit 40.
- First read-data bit: driven 1 `mclk` after the detected falling edge of the last dummy bit, so it is valid before the next `sclk` rise given `sclk` ≤ `mclk`/8.
- `reg_ack` in the same cycle the request asserts is legal; the request is then high for exactly 1 cycle.
- Simultaneous `ssn` rising edge and final-bit `sclk` edge: `ssn` wins and the frame is discarded.
- `reg_ack` with no request pending is ignored.

## Structure
- Package `spis_pkg`: opcode constants `SPIS_CMD_WR`/`SPIS_CMD_RD`, FSM state enum (IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE), frame-length constants.
- Sub-module `spis_sync`: `SYNC_STAGES` flop chains plus edge detection. Outputs `sclk_rise`, `sclk_fall`, `ssn_sync`, `ssn_rise`, `ssn_fall`, `sdin_sync`.
- Top level holds the FSM, shift register, counter, request holding and read shadow.

## Test plan
- Write: frame 0x1F, addr 0x3000_0010, data 0xA5A5_1234. Require `reg_wr` = 1, `reg_be` = 0xF, `reg_addr` = 0x3000_0010, `reg_wdata` = 0xA5A5_1234. Ack after 5 cycles; `reg_wr` drops the next cycle.
- Read: frame 0x23, addr 0x0000_0040. Ack with rdata 0xDEAD_BEEF within the dummy phase. Require `reg_be` = 0x3 and `sdout` bits = 0xDEAD_BEEF MSB first, with `sdout_oen` low only during those 32 bits.
- Late ack: read frame with ack after the data phase starts. Host reads 0x0000_0000; `reg_rd` is still held until the ack.
- Bad opcode 0x5F plus 64 bits: no request, `sdout_oen` stays 1. The next valid write is decoded correctly.
- Abort: `ssn` released after 20 address bits. No request. The following full write frame is decoded correctly.
- Reset asserted while `reg_rd` is pending. All outputs return to their reset values asynchronously, and the FSM is back in IDLE on reset release.
